// File: rtl/dpc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : dpc_pkg
// Description : Shared definitions for the bad-pixel readout path.
//               - Layout of one bad-pixel list entry (x in the low half,
//                 y in the high half of a 32-bit word).
//               - Readout controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package dpc_pkg;

  // Entry packing
  localparam int X_LSB   = 0;
  localparam int Y_LSB   = 16;
  localparam int ENTRY_W = 32;
  localparam int COORD_W = 16;

  // Readout controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bp_list_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : bp_list_fifo2
// Description : Two-entry FIFO holding list entries between the BRAM read
//               port and the AXI-Stream output. The writer guarantees it
//               never pushes when full and the reader never pops when empty.
// Ports       : clk_i    - clock
//               rst_i    - asynchronous active-high reset (empties the FIFO)
//               push_i   - write data_i this cycle
//               data_i   - entry to write
//               pop_i    - drop the head entry this cycle
//               data_o   - head entry
//               empty_o  - no entry stored
//               count_o  - number of stored entries (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module bp_list_fifo2 #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         empty_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;

  assign count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the occupancy count alone decides validity.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/bp_list_reader.sv
`default_nettype none
// ============================================================================
// Module      : bp_list_reader
// Description : Reads the stored bad-pixel list out of a BRAM after a frame
//               and streams the entries on an AXI-Stream master. tuser marks
//               the first entry, tlast the final one.
// Ports       : aclk, areset          - clock, async active-high reset
//               start, bp_count       - readout request and entry count
//               rd_en, rd_addr        - BRAM read request (1-cycle latency)
//               rd_data               - BRAM read data {y[15:0], x[15:0]}
//               m_axis_*              - AXI-Stream master
//               busy, done            - readout in progress / completion pulse
//               m_axis_terr, err_count (only with the coordinate check)
// Options     : BP_LIST_READER_COORD_CHECK_EN - flags entries outside the
//               frame on m_axis_terr and counts them in err_count.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_list_reader
  import dpc_pkg::*;
#(
  parameter int CNT_WIDTH    = 10,
  parameter int AUTO_BP_BIT  = 8,
  parameter int FRAME_WIDTH  = 10,
  parameter int FRAME_HEIGHT = 10
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   start,
  input  logic [AUTO_BP_BIT-1:0] bp_count,
  output logic                   rd_en,
  output logic [AUTO_BP_BIT-1:0] rd_addr,
  input  logic [ENTRY_W-1:0]     rd_data,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [ENTRY_W-1:0]     m_axis_tdata,
  output logic                   m_axis_tuser,
  output logic                   m_axis_tlast,
  output logic                   busy,
  output logic                   done
`ifdef BP_LIST_READER_COORD_CHECK_EN
  ,
  output logic                   m_axis_terr,
  output logic [AUTO_BP_BIT-1:0] err_count
`endif
);

  // Coordinates must fit in their entry fields and the frame in the
  // coordinate range; anything else is a configuration error.
  if (CNT_WIDTH < 1 || CNT_WIDTH > (Y_LSB - X_LSB) || CNT_WIDTH > (ENTRY_W - Y_LSB) ||
      FRAME_WIDTH < 1 || FRAME_WIDTH > (1 << CNT_WIDTH) ||
      FRAME_HEIGHT < 1 || FRAME_HEIGHT > (1 << CNT_WIDTH) ||
      AUTO_BP_BIT < 1) begin : g_param_check
    $error("bp_list_reader: inconsistent parameters");
  end

  state_t                 state_q, state_d;
  logic [AUTO_BP_BIT-1:0] cnt_q, cnt_d;
  logic [AUTO_BP_BIT-1:0] rd_idx_q, rd_idx_d;
  logic [AUTO_BP_BIT-1:0] emit_idx_q, emit_idx_d;
  logic                   inflight_q;

  logic [ENTRY_W-1:0]     fifo_head;
  logic                   fifo_empty;
  logic [1:0]             fifo_count;
  logic                   beat_fire;
  logic                   last_beat;
  logic [1:0]             level;

  assign beat_fire = m_axis_tvalid && m_axis_tready;
  assign last_beat = (emit_idx_q == cnt_q - AUTO_BP_BIT'(1));

  // Entries the FIFO must still absorb once this cycle's pop is taken.
  // Crediting the pop keeps one read per cycle flowing under full
  // throughput while never exceeding the two FIFO slots.
  assign level = fifo_count + {1'b0, inflight_q} - {1'b0, beat_fire};

  assign rd_en   = (state_q == RUN) && (rd_idx_q < cnt_q) && (level < 2'd2);
  assign rd_addr = rd_idx_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_idx_d   = rd_idx_q;
    emit_idx_d = emit_idx_q;
    if (rd_en)     rd_idx_d   = rd_idx_q + AUTO_BP_BIT'(1);
    if (beat_fire) emit_idx_d = emit_idx_q + AUTO_BP_BIT'(1);
    case (state_q)
      RUN: begin
        if (beat_fire && last_beat) state_d = DONE;
      end
      default: begin
        // IDLE and the DONE pulse cycle both accept a new start.
        state_d = IDLE;
        if (start) begin
          cnt_d      = bp_count;
          rd_idx_d   = '0;
          emit_idx_d = '0;
          state_d    = (bp_count == '0) ? DONE : RUN;
        end
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_idx_q   <= '0;
      emit_idx_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_idx_q   <= rd_idx_d;
      emit_idx_q <= emit_idx_d;
      inflight_q <= rd_en;
    end
  end

  bp_list_fifo2 #(
    .W (ENTRY_W)
  ) u_fifo (
    .clk_i   (aclk),
    .rst_i   (areset),
    .push_i  (inflight_q),
    .data_i  (rd_data),
    .pop_i   (beat_fire),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = fifo_head;
  assign m_axis_tuser  = m_axis_tvalid && (emit_idx_q == '0);
  assign m_axis_tlast  = m_axis_tvalid && last_beat;

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

`ifdef BP_LIST_READER_COORD_CHECK_EN
  logic                   coord_bad;
  logic [AUTO_BP_BIT-1:0] err_count_q, err_count_d;

  assign coord_bad = (32'(fifo_head[X_LSB +: COORD_W]) >= 32'(FRAME_WIDTH)) ||
                     (32'(fifo_head[Y_LSB +: COORD_W]) >= 32'(FRAME_HEIGHT));
  assign m_axis_terr = m_axis_tvalid && coord_bad;

  always_comb begin
    err_count_d = err_count_q;
    if (state_q != RUN && start)
      err_count_d = '0;
    else if (beat_fire && m_axis_terr && (err_count_q != '1))
      err_count_d = err_count_q + AUTO_BP_BIT'(1);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) err_count_q <= '0;
    else        err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_list_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_bp_list_reader
// Description : Self-checking bench for bp_list_reader. A transaction-level
//               model predicts the beat stream, busy/done and read addresses
//               from the start requests; directed tests pin the model with
//               hand-computed literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_list_reader;

  localparam int AB = 8;
  localparam int FW = 10;
  localparam int FH = 10;

  logic          clk = 1'b0;
  logic          areset = 1'b1;
  logic          start = 1'b0;
  logic [AB-1:0] bp_count = '0;
  logic          rd_en;
  logic [AB-1:0] rd_addr;
  logic [31:0]   rd_data = '0;
  logic          tvalid;
  logic          tready = 1'b1;
  logic [31:0]   tdata;
  logic          tuser;
  logic          tlast;
  logic          busy;
  logic          done;
`ifdef BP_LIST_READER_COORD_CHECK_EN
  logic          m_axis_terr;
  logic [AB-1:0] err_count;
`endif

  always #5 clk = ~clk;

  bp_list_reader #(
    .CNT_WIDTH    (10),
    .AUTO_BP_BIT  (AB),
    .FRAME_WIDTH  (FW),
    .FRAME_HEIGHT (FH)
  ) dut (
    .aclk          (clk),
    .areset        (areset),
    .start         (start),
    .bp_count      (bp_count),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tdata  (tdata),
    .m_axis_tuser  (tuser),
    .m_axis_tlast  (tlast),
    .busy          (busy),
    .done          (done)
`ifdef BP_LIST_READER_COORD_CHECK_EN
    ,
    .m_axis_terr   (m_axis_terr),
    .err_count     (err_count)
`endif
  );

  // BRAM with one cycle of read latency
  logic [31:0] mem [256];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model + compare ----------------
  typedef struct { logic [31:0] d; logic u; logic l; } beat_t;
  beat_t       exp_q[$];
  logic [31:0] beat_log[$];
  int  cyc = 0, m_cnt = 0, m_rd = 0, m_hs = 0, max_out = 0;
  int  n_beats = 0, n_done = 0;
  int  first_rd_cyc = 0, first_beat_cyc = 0, last_beat_cyc = 0, done_cyc = 0;
  logic [31:0] first_rd_addr = '0;
  bit  m_busy = 0, m_done = 0, stall_prev = 0;
  logic [31:0] prev_data = '0;
  logic prev_user = 0, prev_last = 0;

  always @(negedge clk) begin
    bit    nb, nd;
    int    outst;
    beat_t it;
    cyc++;
    if (areset) begin
      chk("rst_tvalid", tvalid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_rd_addr", rd_addr, 0);
      exp_q.delete();
      m_busy = 0; m_done = 0; stall_prev = 0; m_rd = 0; m_hs = 0; m_cnt = 0;
    end else begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      if (done) begin n_done++; done_cyc = cyc; end
      if (rd_en) begin
        chk("rd_en_allowed", (m_busy && m_rd < m_cnt), 1);
        chk("rd_addr", rd_addr, m_rd);
        if (m_rd == 0) begin first_rd_cyc = cyc; first_rd_addr = rd_addr; end
        m_rd++;
      end
      if (stall_prev) begin
        chk("hold_tvalid", tvalid, 1);
        chk("hold_tdata", tdata, prev_data);
        chk("hold_tuser", tuser, prev_user);
        chk("hold_tlast", tlast, prev_last);
      end
      nb = m_busy; nd = 0;
      if (tvalid) begin
        if (exp_q.size() == 0) chk("beat_expected", 0, 1);
        else begin
          chk("tdata", tdata, exp_q[0].d);
          chk("tuser", tuser, exp_q[0].u);
          chk("tlast", tlast, exp_q[0].l);
`ifdef BP_LIST_READER_COORD_CHECK_EN
          chk("terr", m_axis_terr, (tdata[15:0] >= FW) || (tdata[31:16] >= FH));
`endif
          if (tready) begin
            it = exp_q.pop_front();
            beat_log.push_back(tdata);
            n_beats++; m_hs++;
            if (it.u) first_beat_cyc = cyc;
            if (it.l) begin last_beat_cyc = cyc; nb = 0; nd = 1; end
          end
        end
      end
      if (rd_en) begin
        outst = m_rd - m_hs;
        if (outst > max_out) max_out = outst;
        chk("outstanding_le2", (outst <= 2), 1);
      end
      stall_prev = tvalid && !tready;
      prev_data = tdata; prev_user = tuser; prev_last = tlast;
      if (start && !m_busy) begin
        m_cnt = bp_count; m_rd = 0; m_hs = 0;
        for (int i = 0; i < int'(bp_count); i++)
          exp_q.push_back('{d: mem[i], u: (i == 0), l: (i == int'(bp_count) - 1)});
        if (bp_count == 0) begin nb = 0; nd = 1; end
        else nb = 1;
      end
      m_busy = nb; m_done = nd;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start(input int n);
    @(posedge clk); #1;
    bp_count = AB'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    int d0 = n_done;
    while (n_done == d0 && k < budget) begin @(posedge clk); k++; end
    chk("done_within_budget", (n_done != d0), 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_beats(input int target, input int budget);
    int k = 0;
    while (n_beats < target && k < budget) begin @(posedge clk); #1; k++; end
    chk("beat_within_budget", (n_beats >= target), 1);
  endtask

  int b0, d0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'h00030002;
    mem[1] = 32'h00040006;
    mem[2] = 32'h00070008;
    repeat (3) @(posedge clk);
    #1 areset = 1'b0;
    repeat (2) @(posedge clk);

    // Basic readout
    beat_log.delete(); b0 = n_beats; d0 = n_done;
    pulse_start(3);
    wait_done(40);
    chk("t1_beats", n_beats - b0, 3);
    chk("t1_beat0", beat_log[0], 32'h00030002);
    chk("t1_beat1", beat_log[1], 32'h00040006);
    chk("t1_beat2", beat_log[2], 32'h00070008);
    chk("t1_latency", first_beat_cyc - first_rd_cyc, 2);
    chk("t1_done_after_last", done_cyc - last_beat_cyc, 1);
    chk("t1_done_count", n_done - d0, 1);

    // Backpressure after the first beat
    beat_log.delete(); b0 = n_beats; max_out = 0;
    pulse_start(3);
    wait_beats(b0 + 1, 40);
    tready = 1'b0;
    repeat (5) @(posedge clk);
    #1 tready = 1'b1;
    wait_done(40);
    chk("t2_beats", n_beats - b0, 3);
    chk("t2_beat1", beat_log[1], 32'h00040006);
    chk("t2_beat2", beat_log[2], 32'h00070008);
    chk("t2_max_outstanding", max_out, 2);

    // Empty list
    b0 = n_beats; d0 = n_done;
    pulse_start(0);
    wait_done(10);
    repeat (4) @(posedge clk);
    chk("t3_no_beats", n_beats - b0, 0);
    chk("t3_one_done", n_done - d0, 1);

    // Reset in the middle of a readout
    pulse_start(3);
    wait_beats(n_beats + 1, 40);
    areset = 1'b1;
    #1;
    chk("t4_tvalid_drop", tvalid, 0);
    chk("t4_busy_drop", busy, 0);
    repeat (2) @(posedge clk);
    #1 areset = 1'b0;
    first_rd_addr = 32'hFFFF_FFFF; b0 = n_beats;
    pulse_start(3);
    wait_done(40);
    chk("t4_restart_addr", first_rd_addr, 0);
    chk("t4_restart_beats", n_beats - b0, 3);

    // Start while busy is ignored
    b0 = n_beats; d0 = n_done;
    pulse_start(3);
    pulse_start(3);
    wait_done(40);
    repeat (10) @(posedge clk);
    chk("t5_beats", n_beats - b0, 3);
    chk("t5_dones", n_done - d0, 1);

`ifdef BP_LIST_READER_COORD_CHECK_EN
    // Coordinate check: x=12 lies outside a 10-pixel-wide frame
    mem[0] = 32'h0003000C;
    pulse_start(1);
    wait_done(20);
    chk("t6_err_count", err_count, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal;
  end

endmodule
`default_nettype wire
